kbd_event_tracker: RTL and testbench
====================================

Name: kbd_event_tracker

Overview:
- Turns the raw PS/2 scan-code byte stream from the keyboard receiver into key events.
- Decodes the 0xF0 break prefix and 0xE0 extended prefix, tracks the held key, and counts distinct presses in a COUNT_W-bit counter.
- Keeps a DEPTH-entry history of recent pressed keys.
- Sits between the PS/2 receiver and the key-to-ASCII / seven-segment display logic, and replaces ad-hoc press/count tracking.

Parameters:
- COUNT_W, 8, width of press counter (wraps)
- DEPTH, 8, history entries (power of 2, >=2)
- IDX_W, $clog2(DEPTH), history index width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- code_valid  in  1  scan-code byte available
- code  in  8  scan-code byte
- code_ready  out  1  block accepts byte this cycle
- is_press  out  1  a key is currently held
- key  out  8  last pressed make code
- key_ext  out  1  last pressed key was E0-extended
- count  out  COUNT_W  number of distinct presses
- event_valid  out  1  one-cycle pulse per press/release event
- event_break  out  1  qualifies event_valid: 1 = release, 0 = press
- event_repeat  out  1  qualifies event_valid: typematic repeat
- err  out  1  one-cycle pulse on error byte
- hist_rd_idx  in  IDX_W  history read index, 0 = newest
- hist_rd_data  out  9  {ext, code} at hist_rd_idx (combinational read)
- hist_level  out  IDX_W+1  valid history entries (saturates at DEPTH)

Behaviour:
- Reset (rst==0 at a clk edge):
  - is_press=0, key=0x00, key_ext=0, count=0.
  - event_*=0, err=0, hist_level=0, all history entries=0.
  - FSM=IDLE, code_ready=0.
  - Reset mid-prefix discards the partial sequence.
- code_ready=1 in every cycle after reset. A byte is accepted when code_valid&&code_ready.
- Latency: outputs and pulses update on the edge after acceptance (1 cycle). One byte is processed per cycle, back-to-back.
- FSM states: IDLE, EXT, BRK, EXT_BRK. On an accepted byte b:
  - IDLE: b=0xE0 -> EXT; b=0xF0 -> BRK; else make(b, ext=0), stay IDLE.
  - EXT: b=0xF0 -> EXT_BRK; b=0xE0 -> stay EXT; else make(b, ext=1) -> IDLE.
  - BRK: break(b, ext=0) -> IDLE.
  - EXT_BRK: break(b, ext=1) -> IDLE.
  - In any state, b=0x00 or b=0xFF: err=1 for one cycle -> IDLE, no other change.
- make(c,e):
  - If is_press && key==c && key_ext==e, it is a typematic repeat. Behaviour is set by the optional feature.
  - Otherwise: key<=c, key_ext<=e, is_press<=1, count<=count+1 (0 follows 2^COUNT_W-1). Push {e,c} into history; hist_level increments up to DEPTH. event_valid=1, event_break=0, event_repeat=0.
- break(c,e):
  - If is_press && key==c && key_ext==e: is_press<=0, event_valid=1, event_break=1. key and count are unchanged.
  - Otherwise (release of a non-tracked key): ignored, no pulse.
- History is circular:
  - A write at full level overwrites the oldest entry.
  - hist_rd_idx >= hist_level returns 9'h000.
- code_valid while code_ready=0 (reset) is dropped.

Optional Feature:
- KBD_REPEAT_EN defined:
  - A typematic repeat produces event_valid=1, event_repeat=1, event_break=0 and increments count.
  - History is not pushed.
- Not defined:
  - Repeats are absorbed silently: no pulse, count unchanged.
  - event_repeat is tied to 0.

Decomposition:
- Package kbd_pkg:
  - constants PS2_EXT_PREFIX=8'hE0, PS2_BRK_PREFIX=8'hF0, PS2_ERR_LO=8'h00, PS2_ERR_HI=8'hFF
  - FSM state enum kbd_state_t
  - typedef kbd_key_t = struct {ext, code[7:0]}
- One sub-module, kbd_hist_buf:
  - DEPTH x 9 register ring with write pointer and level.
  - Combinational read by age index.
  - Reset clears entries, pointer and level.

Test Plan:
- Bytes 0x1C, 0xF0, 0x1C -> after byte1: is_press=1, key=0x1C, count=1, event press. After byte3: is_press=0, event_break pulse, key stays 0x1C.
- Bytes 0xE0, 0x75, 0xE0, 0xF0, 0x75 -> key=0x75, key_ext=1, count=1. Release pulse with ext match. hist_rd_data[idx0]=0x175.
- Bytes 0x1C x5 held -> without KBD_REPEAT_EN count=1 with one pulse. With KBD_REPEAT_EN count=5 and four event_repeat pulses.
- 0x1C, then 0xF0, 0x32 (other key) -> break ignored, is_press stays 1, no pulse.
- 2^COUNT_W+1 distinct presses (alternate 0x1C/0x32) with DEPTH=8 -> count wraps to 1, hist_level=8, idx0=newest, idx7 = 8th newest.
- 0xE0, then rst low one cycle, then 0x1C -> plain make with key_ext=0, count=1. Separately, byte 0xFF mid-BRK -> err pulse, FSM IDLE, state unchanged.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared PS/2 key-event definitions: prefix bytes, decoder state encoding and history entry format.
package kbd_pkg;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
    localparam logic [7:0] PS2_ERR_LO     = 8'h00;
    localparam logic [7:0] PS2_ERR_HI     = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_t;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } kbd_key_t;

    function automatic logic is_err_byte(input logic [7:0] b);
        return (b == PS2_ERR_LO) || (b == PS2_ERR_HI);
    endfunction

endpackage

// File: rtl/kbd_hist_buf.sv
// Circular history of recently pressed keys, read combinationally by age (0 = newest).
module kbd_hist_buf
    import kbd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  kbd_key_t         push_data,
    input  logic [IDX_W-1:0] rd_idx,
    output kbd_key_t         rd_data,
    output logic [IDX_W:0]   level
);

    localparam logic [IDX_W:0] LEVEL_FULL = (IDX_W+1)'(DEPTH);

    kbd_key_t         mem [DEPTH];
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_slot;

    // wr_ptr always names the slot the next push lands in, so once full it is also the oldest entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            level  <= '0;
        end else if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + IDX_W'(1);
            if (level != LEVEL_FULL) begin
                level <= level + (IDX_W+1)'(1);
            end
        end
    end

    assign rd_slot = wr_ptr - rd_idx - IDX_W'(1);

    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_idx} < level) begin
            rd_data = mem[rd_slot];
        end
    end

endmodule

// File: rtl/kbd_event_tracker.sv
// PS/2 scan-code stream to key press/release events with press counter and key history.
// Define KBD_REPEAT_EN to report typematic repeats as events that also advance the counter.
module kbd_event_tracker
    import kbd_pkg::*;
#(
    parameter int COUNT_W = 8,
    parameter int DEPTH   = 8,
    parameter int IDX_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               code_valid,
    input  logic [7:0]         code,
    output logic               code_ready,
    output logic               is_press,
    output logic [7:0]         key,
    output logic               key_ext,
    output logic [COUNT_W-1:0] count,
    output logic               event_valid,
    output logic               event_break,
    output logic               event_repeat,
    output logic               err,
    input  logic [IDX_W-1:0]   hist_rd_idx,
    output logic [8:0]         hist_rd_data,
    output logic [IDX_W:0]     hist_level
);

    kbd_state_t state, state_nxt;
    logic       accept;
    logic       make_req, brk_req, err_req;
    logic       ev_ext;
    logic       matches_held;
    logic       hist_push;
    kbd_key_t   hist_rd_key;

    assign accept = code_valid && code_ready;

    always_comb begin
        state_nxt = state;
        make_req  = 1'b0;
        brk_req   = 1'b0;
        err_req   = 1'b0;
        ev_ext    = 1'b0;
        if (accept) begin
            if (is_err_byte(code)) begin
                err_req   = 1'b1;
                state_nxt = ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (code == PS2_EXT_PREFIX) begin
                            state_nxt = ST_EXT;
                        end else if (code == PS2_BRK_PREFIX) begin
                            state_nxt = ST_BRK;
                        end else begin
                            make_req = 1'b1;
                        end
                    end
                    ST_EXT: begin
                        if (code == PS2_BRK_PREFIX) begin
                            state_nxt = ST_EXT_BRK;
                        end else if (code != PS2_EXT_PREFIX) begin
                            make_req  = 1'b1;
                            ev_ext    = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        brk_req   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                    ST_EXT_BRK: begin
                        brk_req   = 1'b1;
                        ev_ext    = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    // A make of the key already held is a typematic repeat and never enters the history.
    assign matches_held = is_press && (key == code) && (key_ext == ev_ext);
    assign hist_push    = make_req && !matches_held;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            code_ready  <= 1'b0;
            is_press    <= 1'b0;
            key         <= 8'h00;
            key_ext     <= 1'b0;
            count       <= '0;
            event_valid <= 1'b0;
            event_break <= 1'b0;
            err         <= 1'b0;
        end else begin
            code_ready  <= 1'b1;
            state       <= state_nxt;
            err         <= err_req;
            event_valid <= 1'b0;
            event_break <= 1'b0;
            if (hist_push) begin
                key         <= code;
                key_ext     <= ev_ext;
                is_press    <= 1'b1;
                count       <= count + COUNT_W'(1);
                event_valid <= 1'b1;
            end else if (brk_req && matches_held) begin
                is_press    <= 1'b0;
                event_valid <= 1'b1;
                event_break <= 1'b1;
            end
`ifdef KBD_REPEAT_EN
            else if (make_req) begin
                count       <= count + COUNT_W'(1);
                event_valid <= 1'b1;
            end
`endif
        end
    end

`ifdef KBD_REPEAT_EN
    logic repeat_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= make_req && matches_held;
        end
    end

    assign event_repeat = repeat_q;
`else
    assign event_repeat = 1'b0;
`endif

    kbd_hist_buf #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .push      (hist_push),
        .push_data ('{ext: ev_ext, code: code}),
        .rd_idx    (hist_rd_idx),
        .rd_data   (hist_rd_key),
        .level     (hist_level)
    );

    assign hist_rd_data = hist_rd_key;

endmodule

// File: tb/tb_kbd_event_tracker.sv
// Scoreboard bench for kbd_event_tracker: a prefix-flag reference model queues expected
// observations per accepted byte, and a negedge monitor pops and compares them.
module tb_kbd_event_tracker;

    localparam int COUNT_W = 8;
    localparam int DEPTH   = 8;
    localparam int IDX_W   = 3;

    typedef struct packed {
        logic               is_press;
        logic [7:0]         key;
        logic               key_ext;
        logic [COUNT_W-1:0] count;
        logic [IDX_W:0]     level;
        logic               ev;
        logic               brk;
        logic               rep;
        logic               err;
    } obs_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               code_valid = 1'b0;
    logic [7:0]         code = 8'h00;
    logic               code_ready;
    logic               is_press;
    logic [7:0]         key;
    logic               key_ext;
    logic [COUNT_W-1:0] count;
    logic               event_valid;
    logic               event_break;
    logic               event_repeat;
    logic               err;
    logic [IDX_W-1:0]   hist_rd_idx = '0;
    logic [8:0]         hist_rd_data;
    logic [IDX_W:0]     hist_level;

    int checks = 0;
    int errors = 0;

    obs_t exp_q[$];

    // Reference model: pending prefixes, held key, press total and newest-first history.
    bit          m_ext, m_brk, m_held, m_kext;
    logic [7:0]  m_key;
    int          m_cnt;
    logic [8:0]  m_hist[$];

    kbd_event_tracker #(
        .COUNT_W (COUNT_W),
        .DEPTH   (DEPTH),
        .IDX_W   (IDX_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .code_valid   (code_valid),
        .code         (code),
        .code_ready   (code_ready),
        .is_press     (is_press),
        .key          (key),
        .key_ext      (key_ext),
        .count        (count),
        .event_valid  (event_valid),
        .event_break  (event_break),
        .event_repeat (event_repeat),
        .err          (err),
        .hist_rd_idx  (hist_rd_idx),
        .hist_rd_data (hist_rd_data),
        .hist_level   (hist_level)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic obs_t modelObs(input bit ev, input bit brk, input bit rep, input bit er);
        obs_t o;
        o.is_press = m_held;
        o.key      = m_key;
        o.key_ext  = m_kext;
        o.count    = COUNT_W'(m_cnt);
        o.level    = (IDX_W+1)'(m_hist.size());
        o.ev       = ev;
        o.brk      = brk;
        o.rep      = rep;
        o.err      = er;
        return o;
    endfunction

    task automatic applyStimulus(input logic [7:0] b);
        bit ev = 0, brk = 0, rep = 0, er = 0;
        if (b == 8'h00 || b == 8'hFF) begin
            er = 1; m_ext = 0; m_brk = 0;
        end else if (m_brk) begin
            if (m_held && m_key == b && m_kext == m_ext) begin
                m_held = 0; ev = 1; brk = 1;
            end
            m_ext = 0; m_brk = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else begin
            if (m_held && m_key == b && m_kext == m_ext) begin
`ifdef KBD_REPEAT_EN
                ev = 1; rep = 1; m_cnt = (m_cnt + 1) % (1 << COUNT_W);
`endif
            end else begin
                m_held = 1; m_key = b; m_kext = m_ext;
                m_cnt = (m_cnt + 1) % (1 << COUNT_W);
                m_hist.push_front({m_ext, b});
                if (m_hist.size() > DEPTH) void'(m_hist.pop_back());
                ev = 1;
            end
            m_ext = 0;
        end
        exp_q.push_back(modelObs(ev, brk, rep, er));
        code_valid = 1'b1;
        code       = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        code_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Bytes offered during reset and in the release cycle must be dropped.
    task automatic doReset(input int cyc);
        rst        = 1'b0;
        code_valid = 1'b1;
        code       = 8'h1C;
        repeat (cyc) @(negedge clk);
        m_ext = 0; m_brk = 0; m_held = 0; m_kext = 0; m_key = 8'h00; m_cnt = 0;
        m_hist.delete();
        rst = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    task automatic checkHistory(input string name);
        logic [8:0] exp;
        code_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hist_rd_idx = IDX_W'(i);
            #1;
            exp = (i < m_hist.size()) ? m_hist[i] : 9'h000;
            checkOutput($sformatf("%s_hist%0d", name, i), 32'(hist_rd_data), 32'(exp));
        end
        hist_rd_idx = '0;
        @(negedge clk);
    endtask

    // Monitor: capture acceptance at the edge, compare the registered response half a cycle later.
    logic acc_q       = 1'b0;
    logic ready_exp   = 1'b0;
    bit   ready_known = 0;
    obs_t cur         = '0;

    always @(posedge clk) begin
        acc_q = rst && code_valid && (code_ready === 1'b1);
        if (!rst) begin
            ready_exp   = 1'b0;
            ready_known = 1;
            cur         = '0;
        end else begin
            ready_exp = 1'b1;
        end
    end

    always @(negedge clk) begin
        obs_t act;
        obs_t e;
        if (ready_known) begin
            act = {is_press, key, key_ext, count, hist_level,
                   event_valid, event_break, event_repeat, err};
            checkOutput("code_ready", 32'(code_ready), 32'(ready_exp));
            if (acc_q) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_accept actual=accepted expected=none at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("accept", 32'(act), 32'(e));
                    cur     = e;
                    cur.ev  = 1'b0;
                    cur.brk = 1'b0;
                    cur.rep = 1'b0;
                    cur.err = 1'b0;
                end
            end else begin
                checkOutput("hold", 32'(act), 32'(cur));
            end
        end
    end

    initial begin
        logic [7:0] keys [4];
        int r, p;
        keys = '{8'h1C, 8'h32, 8'h75, 8'h23};

        $display("[TB] start");
        doReset(2);

        applyStimulus(8'h1C); applyStimulus(8'hF0); applyStimulus(8'h1C);
        idle(2);

        doReset(1);
        applyStimulus(8'hE0); applyStimulus(8'h75);
        applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
        checkHistory("ext");

        doReset(1);
        repeat (5) applyStimulus(8'h1C);
        applyStimulus(8'hF0); applyStimulus(8'h32);
        applyStimulus(8'hF0); applyStimulus(8'hFF);
        applyStimulus(8'h1C);
        applyStimulus(8'hF0); applyStimulus(8'h1C);
        idle(1);

        doReset(1);
        for (int i = 0; i < (1 << COUNT_W) + 1; i++) begin
            applyStimulus((i % 2 == 0) ? 8'h1C : 8'h32);
        end
        checkHistory("wrap");

        applyStimulus(8'hE0);
        doReset(1);
        applyStimulus(8'h1C);
        idle(1);

        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 1) begin
                doReset(1 + $urandom_range(0, 2));
            end else if (r < 8) begin
                idle(1 + $urandom_range(0, 2));
            end else begin
                p = $urandom_range(0, 99);
                if (p < 50)      applyStimulus(keys[$urandom_range(0, 3)]);
                else if (p < 70) applyStimulus(8'hE0);
                else if (p < 90) applyStimulus(8'hF0);
                else if (p < 95) applyStimulus(8'h00);
                else             applyStimulus(8'hFF);
            end
        end
        checkHistory("rand");
        idle(3);

        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
